trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the bit width of one probe channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of probed signals captured per sample.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning samples stored; power of two, >= 4; AW = log2(DEPTH).
REQ-004 The block SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port probe  input  CHANNELS*WIDTH  probed signals; channel 0 is bits [WIDTH-1:0].
REQ-007 The block SHALL have port arm  input  1  start/restart a capture.
REQ-008 The block SHALL have port trig_ext  input  1  external trigger.
REQ-009 The block SHALL have ports trig_mask and trig_value  input  WIDTH  channel-0 match trigger.
REQ-010 The block SHALL have port post_count  input  AW+1  samples taken after the trigger sample.
REQ-011 The block SHALL have port state  output  2  00 IDLE, 01 ARMED, 10 POST, 11 READ.
REQ-012 The block SHALL have port wrapped  output  1  older samples were overwritten.
REQ-013 The block SHALL have ports rd_valid  output  1, rd_ready  input  1, rd_data  output  CHANNELS*WIDTH, rd_last  output  1  readout stream.

Function
REQ-014 In IDLE, arm=1 at a rising edge SHALL clear write pointer, fill count and wrapped, and enter ARMED.
REQ-015 In ARMED and POST, every rising edge SHALL write probe to mem[wptr]. wptr increments modulo DEPTH. Fill count saturates at DEPTH.
REQ-016 wrapped SHALL be set on the edge where a write occurs with fill count already DEPTH. It stays set until the next arm or reset.
REQ-017 In ARMED, a written sample SHALL be the trigger sample if trig_ext=1 or ((probe ch0 & trig_mask) == (trig_value & trig_mask) with trig_mask != 0).
  - trig_mask = 0 disables the match trigger.
REQ-018 On the trigger sample, the block SHALL latch remaining = min(post_count, DEPTH-1).
  - remaining = 0: next state is READ.
  - otherwise: next state is POST.
REQ-019 In POST, each write SHALL decrement remaining; the write that brings remaining to 0 SHALL transition to READ.
  - trig_ext and the match trigger are ignored in POST.
REQ-020 On entering READ, the read pointer SHALL be set to the oldest sample: wptr if fill = DEPTH, else 0. The beat count SHALL be set to the fill count.
REQ-021 In READ, rd_valid SHALL be 1 and rd_data SHALL equal mem[rptr], starting in the first READ cycle. No writes occur in READ.
REQ-022 A beat SHALL transfer when rd_valid & rd_ready at a rising edge; rptr then advances modulo DEPTH.
  - With rd_ready=0, rd_data and rd_last SHALL hold stable.
REQ-023 rd_last SHALL be 1 only on the final beat. Its transfer SHALL return state to IDLE with rd_valid=0.
REQ-024 arm=1 in ARMED, POST or READ SHALL abort the current capture and restart as in REQ-014; arm has priority over trigger and readout.
REQ-025 Total samples read SHALL equal min(t+1+p, DEPTH), where t = trigger sample index since arm and p = clamped post_count. The samples are the most recent ones, in write order.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force state=00, wrapped=0, rd_valid=0, rd_last=0, and clear pointers and counters. Memory contents need not be cleared.
REQ-027 rd_data SHALL be don't-care whenever rd_valid=0.
REQ-028 Reset asserted mid-capture or mid-readout SHALL discard the capture; after release the block stays IDLE until arm.

Verification (WIDTH=64, CHANNELS=4, DEPTH=16; ch0 driven with sample index 0,1,2,… after arm; ch1..3 = ch0 XOR constants)
REQ-029 The bench SHALL check reset: assert reset=0 mid-run -> state=00, rd_valid=0, wrapped=0 immediately, without waiting for a clock edge.
REQ-030 The bench SHALL check the basic trigger: trig_ext=1 at sample 5, post_count=2 -> 8 beats, ch0 = 0..7, rd_last on beat 8, wrapped=0, then state=00.
REQ-031 The bench SHALL check wrap plus match: trig_mask=all-ones, trig_value=30, post_count=3 -> wrapped=1, 16 beats, ch0 = 18..33.
REQ-032 The bench SHALL check backpressure: rd_ready=0 for 3 cycles after beat 4 -> rd_data held at beat-4 value; no beat lost or duplicated.
REQ-033 The bench SHALL check post_count clamping and the mask-zero case:
  - trig_ext at sample 0, post_count=20 -> clamped to 15; 16 beats, ch0 = 0..15.
  - trig_mask=0 with any trig_value -> never triggers.
REQ-034 The bench SHALL check restart: arm re-asserted at sample 10 in ARMED -> fill restarts; a trigger at new sample 2 with post_count=0 -> 3 beats, ch0 = new indices 0..2.

Source files
------------

// File: rtl/trace_capture_if.sv
// Readout stream of the trace capture block: one stored sample per beat,
// valid/ready handshake, last marks the final stored sample.
interface trace_capture_if #(
    parameter int DATA_W = 256
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/trace_capture.sv
// Circular trace buffer: after arm, every cycle stores all probe channels,
// a trigger (external or channel-0 mask/value match) starts a post-trigger
// countdown, then the most recent samples are streamed out oldest first.
module trace_capture #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS*WIDTH-1:0]     probe,
    input  logic                          arm,
    input  logic                          trig_ext,
    input  logic [WIDTH-1:0]              trig_mask,
    input  logic [WIDTH-1:0]              trig_value,
    input  logic [$clog2(DEPTH):0]        post_count,
    output logic [1:0]                    state,
    output logic                          wrapped,
    trace_capture_if.master               rd
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_READ  = 2'b11
    } state_t;

    state_t                      state_r, state_n;
    logic [AW-1:0]               wptr_r, wptr_n;
    logic [AW-1:0]               rptr_r, rptr_n;
    logic [AW:0]                 fill_r, fill_n;
    logic [AW:0]                 remaining_r, remaining_n;
    logic [AW:0]                 beats_r, beats_n;
    logic                        wrapped_r, wrapped_n;
    logic                        rd_valid_r, rd_valid_n;
    logic                        rd_last_r, rd_last_n;
    logic                        we_s;
    logic                        go_read_s;
    logic                        trig_s;
    logic [AW-1:0]               wptr_inc_s;
    logic [AW:0]                 fill_inc_s;
    logic [AW:0]                 post_clamp_s;
    logic [CHANNELS*WIDTH-1:0]   mem [DEPTH];

    // A match trigger needs a non-zero mask; a zero mask leaves only trig_ext.
    assign trig_s = trig_ext |
                    (((probe[WIDTH-1:0] & trig_mask) == (trig_value & trig_mask)) &&
                     (trig_mask != {WIDTH{1'b0}}));

    assign wptr_inc_s   = wptr_r + 1'b1;
    assign fill_inc_s   = (fill_r == FULL) ? FULL : (fill_r + 1'b1);
    assign post_clamp_s = (post_count > MAX_POST) ? MAX_POST : post_count;

    // Next-state logic: arm overrides everything, then capture/readout per state.
    always_comb begin
        state_n     = state_r;
        wptr_n      = wptr_r;
        rptr_n      = rptr_r;
        fill_n      = fill_r;
        remaining_n = remaining_r;
        beats_n     = beats_r;
        wrapped_n   = wrapped_r;
        rd_valid_n  = rd_valid_r;
        rd_last_n   = rd_last_r;
        we_s        = 1'b0;
        go_read_s   = 1'b0;

        if (arm) begin
            state_n    = ST_ARMED;
            wptr_n     = {AW{1'b0}};
            fill_n     = {(AW+1){1'b0}};
            wrapped_n  = 1'b0;
            rd_valid_n = 1'b0;
            rd_last_n  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_ARMED: begin
                    we_s      = 1'b1;
                    wptr_n    = wptr_inc_s;
                    fill_n    = fill_inc_s;
                    wrapped_n = wrapped_r | (fill_r == FULL);
                    if (trig_s) begin
                        remaining_n = post_clamp_s;
                        if (post_clamp_s == {(AW+1){1'b0}}) begin
                            go_read_s = 1'b1;
                        end else begin
                            state_n = ST_POST;
                        end
                    end else begin
                        state_n = ST_ARMED;
                    end
                end
                ST_POST: begin
                    we_s      = 1'b1;
                    wptr_n    = wptr_inc_s;
                    fill_n    = fill_inc_s;
                    wrapped_n = wrapped_r | (fill_r == FULL);
                    if (remaining_r <= (AW+1)'(1)) begin
                        remaining_n = {(AW+1){1'b0}};
                        go_read_s   = 1'b1;
                    end else begin
                        remaining_n = remaining_r - 1'b1;
                    end
                end
                ST_READ: begin
                    if (rd_valid_r && rd.rd_ready) begin
                        if (rd_last_r) begin
                            state_n    = ST_IDLE;
                            rd_valid_n = 1'b0;
                            rd_last_n  = 1'b0;
                        end else begin
                            rptr_n    = rptr_r + 1'b1;
                            beats_n   = beats_r - 1'b1;
                            rd_last_n = (beats_r == (AW+1)'(2));
                        end
                    end else begin
                        state_n = ST_READ;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase

            // The oldest sample is judged after this cycle's write lands.
            if (go_read_s) begin
                state_n    = ST_READ;
                rptr_n     = (fill_inc_s == FULL) ? wptr_inc_s : {AW{1'b0}};
                beats_n    = fill_inc_s;
                rd_valid_n = 1'b1;
                rd_last_n  = (fill_inc_s == (AW+1)'(1));
            end else begin
                rptr_n = rptr_n;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            wptr_r      <= {AW{1'b0}};
            rptr_r      <= {AW{1'b0}};
            fill_r      <= {(AW+1){1'b0}};
            remaining_r <= {(AW+1){1'b0}};
            beats_r     <= {(AW+1){1'b0}};
            wrapped_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            wptr_r      <= wptr_n;
            rptr_r      <= rptr_n;
            fill_r      <= fill_n;
            remaining_r <= remaining_n;
            beats_r     <= beats_n;
            wrapped_r   <= wrapped_n;
            rd_valid_r  <= rd_valid_n;
            rd_last_r   <= rd_last_n;
        end
    end

    // Sample storage; contents are not cleared by reset.
    always_ff @(posedge clock) begin
        if (we_s) begin
            mem[wptr_r] <= probe;
        end
    end

    assign state       = state_r;
    assign wrapped     = wrapped_r;
    assign rd.rd_valid = rd_valid_r;
    assign rd.rd_last  = rd_last_r;
    assign rd.rd_data  = mem[rptr_r];
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: table of capture scenarios plus
// hand-written sequences for backpressure, mask zero, restart and reset.
module tb_trace_capture;
    localparam int WIDTH    = 64;
    localparam int CHANNELS = 4;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam logic [63:0] C1 = 64'hA5A5_0000_1111_0001;
    localparam logic [63:0] C2 = 64'h5A5A_FFFF_2222_0002;
    localparam logic [63:0] C3 = 64'hDEAD_BEEF_3333_0003;

    logic                      clock;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] probe;
    logic                      arm;
    logic                      trig_ext;
    logic [WIDTH-1:0]          trig_mask;
    logic [WIDTH-1:0]          trig_value;
    logic [AW:0]               post_count;
    logic [1:0]                state;
    logic                      wrapped;

    int n_checks = 0;
    int n_fail   = 0;
    int idx      = 0;

    trace_capture_if #(.DATA_W(CHANNELS*WIDTH)) rd_if ();

    trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .probe      (probe),
        .arm        (arm),
        .trig_ext   (trig_ext),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .post_count (post_count),
        .state      (state),
        .wrapped    (wrapped),
        .rd         (rd_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        int          trig_at;
        logic        use_ext;
        logic [63:0] mask;
        logic [63:0] value;
        int          pc;
        int          exp_first;
        int          exp_beats;
        logic        exp_wrapped;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [255:0] sample(input int i);
        logic [63:0] c0;
        c0 = 64'(i);
        return {c0 ^ C3, c0 ^ C2, c0 ^ C1, c0};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idx++;
        probe = sample(idx);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        @(posedge clock);
        #1;
        arm   = 1'b0;
        idx   = 0;
        probe = sample(0);
    endtask

    task automatic capture_until_read(input int trig_at, input logic use_ext);
        int guard;
        guard = 0;
        while (state != 2'b11 && guard < 200) begin
            trig_ext = use_ext && (idx == trig_at);
            step();
            guard++;
        end
        trig_ext = 1'b0;
        check("reach_read", 256'(state), 256'(2'b11));
    endtask

    task automatic read_all(input string name, input int first, input int n, input int bp_beat);
        rd_if.rd_ready = 1'b1;
        for (int b = 0; b < n; b++) begin
            check({name, "_valid"}, 256'(rd_if.rd_valid), 256'(1'b1));
            check({name, "_data"}, rd_if.rd_data, sample(first + b));
            check({name, "_last"}, 256'(rd_if.rd_last), 256'(b == n - 1));
            if (b == bp_beat) begin
                rd_if.rd_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check({name, "_hold_data"}, rd_if.rd_data, sample(first + b));
                    check({name, "_hold_last"}, 256'(rd_if.rd_last), 256'(b == n - 1));
                    check({name, "_hold_valid"}, 256'(rd_if.rd_valid), 256'(1'b1));
                end
                rd_if.rd_ready = 1'b1;
            end
            step();
        end
        check({name, "_end_state"}, 256'(state), 256'(2'b00));
        check({name, "_end_valid"}, 256'(rd_if.rd_valid), 256'(1'b0));
    endtask

    initial begin
        vecs[0] = '{"basic_ext", 5, 1'b1, 64'h0, 64'h0, 2, 0, 8, 1'b0};
        vecs[1] = '{"wrap_match", -1, 1'b0, {64{1'b1}}, 64'd30, 3, 18, 16, 1'b1};
        vecs[2] = '{"clamp", 0, 1'b1, 64'h0, 64'h0, 20, 0, 16, 1'b0};
        vecs[3] = '{"single", 0, 1'b1, 64'h0, 64'h0, 0, 0, 1, 1'b0};
        vecs[4] = '{"wrap_pc0", 20, 1'b1, 64'h0, 64'h0, 0, 5, 16, 1'b1};
        vecs[5] = '{"part_mask", -1, 1'b0, 64'hF0, 64'h35, 1, 34, 16, 1'b1};

        reset          = 1'b0;
        arm            = 1'b0;
        trig_ext       = 1'b0;
        trig_mask      = 64'h0;
        trig_value     = 64'h0;
        post_count     = 5'd0;
        rd_if.rd_ready = 1'b1;
        probe          = sample(0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", 256'(state), 256'(2'b00));
        check("rst_valid", 256'(rd_if.rd_valid), 256'(1'b0));
        check("rst_wrapped", 256'(wrapped), 256'(1'b0));
        reset = 1'b1;
        step();
        step();
        check("idle_hold", 256'(state), 256'(2'b00));

        // Table of full capture/readout scenarios.
        for (int v = 0; v < 6; v++) begin
            trig_mask  = vecs[v].mask;
            trig_value = vecs[v].value;
            post_count = 5'(vecs[v].pc);
            arm_pulse();
            check({vecs[v].name, "_armed"}, 256'(state), 256'(2'b01));
            capture_until_read(vecs[v].trig_at, vecs[v].use_ext);
            check({vecs[v].name, "_wrapped"}, 256'(wrapped), 256'(vecs[v].exp_wrapped));
            read_all(vecs[v].name, vecs[v].exp_first, vecs[v].exp_beats, -1);
        end

        // Backpressure on the fourth beat.
        trig_mask  = 64'h0;
        post_count = 5'd2;
        arm_pulse();
        capture_until_read(5, 1'b1);
        read_all("bp", 0, 8, 3);

        // Zero mask never triggers, whatever the value.
        trig_mask  = 64'h0;
        trig_value = 64'h0;
        post_count = 5'd0;
        arm_pulse();
        repeat (40) step();
        check("mask0_state", 256'(state), 256'(2'b01));
        check("mask0_wrapped", 256'(wrapped), 256'(1'b1));

        // Restart from ARMED at sample 10, trigger at new sample 2.
        arm_pulse();
        while (idx < 10) step();
        arm_pulse();
        check("restart_armed", 256'(state), 256'(2'b01));
        check("restart_wrapped", 256'(wrapped), 256'(1'b0));
        post_count = 5'd0;
        capture_until_read(2, 1'b1);
        read_all("restart", 0, 3, -1);

        // Asynchronous reset in the middle of a wrapped readout.
        arm_pulse();
        capture_until_read(20, 1'b1);
        check("pre_rst_wrapped", 256'(wrapped), 256'(1'b1));
        step();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", 256'(state), 256'(2'b00));
        check("async_rst_valid", 256'(rd_if.rd_valid), 256'(1'b0));
        check("async_rst_wrapped", 256'(wrapped), 256'(1'b0));
        check("async_rst_last", 256'(rd_if.rd_last), 256'(1'b0));
        step();
        reset = 1'b1;
        repeat (5) step();
        check("post_rst_idle", 256'(state), 256'(2'b00));
        check("post_rst_valid", 256'(rd_if.rd_valid), 256'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
